// File: rtl/alu_ir_mar_datapath_if.sv
// alu_ir_mar_datapath_if
// Bundles the ALU operand/result/flag signals and the MAR/IR load and data
// signals shared between the control side (master) and the datapath (slave).
interface alu_ir_mar_datapath_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic             carry_in;
    logic [WIDTH-1:0] result;
    logic             FlagZ;
    logic             FlagN;
    logic             FlagC;
    logic             FlagV;
    logic             MARLd;
    logic [WIDTH-1:0] mar_q;
    logic             IRLd;
    logic [WIDTH-1:0] ir_d;
    logic [WIDTH-1:0] ir_q;

    modport master (
        output alu_a, alu_b, alu_op, carry_in, MARLd, IRLd, ir_d,
        input  result, FlagZ, FlagN, FlagC, FlagV, mar_q, ir_q
    );

    modport slave (
        input  alu_a, alu_b, alu_op, carry_in, MARLd, IRLd, ir_d,
        output result, FlagZ, FlagN, FlagC, FlagV, mar_q, ir_q
    );
endinterface

// File: rtl/alu_ir_mar_datapath.sv
// alu_ir_mar_datapath
// Combinational ALU (ARM data-processing op encoding) feeding the Memory
// Address Register, plus the Instruction Register loaded from RAM data-out.
// Optional macro ALU_EXT_OPS_EN enables the address-helper ops 16..21;
// without it, ops 16..31 all behave as reserved (result 0, C=carry_in, V=0).
module alu_ir_mar_datapath #(
    parameter int WIDTH = 32
) (
    input logic                 CLK,
    input logic                 CLR,
    alu_ir_mar_datapath_if.slave bus
);

    typedef enum logic [4:0] {
        OP_AND  = 5'd0,
        OP_EOR  = 5'd1,
        OP_SUB  = 5'd2,
        OP_RSB  = 5'd3,
        OP_ADD  = 5'd4,
        OP_ADC  = 5'd5,
        OP_SBC  = 5'd6,
        OP_RSC  = 5'd7,
        OP_TST  = 5'd8,
        OP_TEQ  = 5'd9,
        OP_CMP  = 5'd10,
        OP_CMN  = 5'd11,
        OP_ORR  = 5'd12,
        OP_MOV  = 5'd13,
        OP_BIC  = 5'd14,
        OP_MVN  = 5'd15,
        OP_INCA = 5'd16,
        OP_PASA = 5'd17,
        OP_PASB = 5'd18,
        OP_ADDA = 5'd19,
        OP_SUBA = 5'd20,
        OP_INCB = 5'd21
    } aluOp_e;

    aluOp_e           aluOp;
    logic [WIDTH-1:0] aluResult;
    logic             flagC;
    logic             flagV;
    logic             isArith;
    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic             addCin;
    logic [WIDTH:0]   sum;

    logic [WIDTH-1:0] marReg_q;
    logic [WIDTH-1:0] marReg_d;
    logic [WIDTH-1:0] irReg_q;
    logic [WIDTH-1:0] irReg_d;

    assign aluOp = aluOp_e'(bus.alu_op);

    // ALU: all arithmetic ops share one adder; subtraction is X + ~Y + cin
    always_comb begin
        aluResult = '0;
        flagC     = bus.carry_in;
        flagV     = 1'b0;
        isArith   = 1'b0;
        addX      = '0;
        addY      = '0;
        addCin    = 1'b0;
        case (aluOp)
            OP_AND, OP_TST: aluResult = bus.alu_a & bus.alu_b;
            OP_EOR, OP_TEQ: aluResult = bus.alu_a ^ bus.alu_b;
            OP_SUB, OP_CMP: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = ~bus.alu_b;
                addCin  = 1'b1;
            end
            OP_RSB: begin
                isArith = 1'b1;
                addX    = bus.alu_b;
                addY    = ~bus.alu_a;
                addCin  = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = bus.alu_b;
            end
            OP_ADC: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = bus.alu_b;
                addCin  = bus.carry_in;
            end
            OP_SBC: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = ~bus.alu_b;
                addCin  = bus.carry_in;
            end
            OP_RSC: begin
                isArith = 1'b1;
                addX    = bus.alu_b;
                addY    = ~bus.alu_a;
                addCin  = bus.carry_in;
            end
            OP_ORR: aluResult = bus.alu_a | bus.alu_b;
            OP_MOV: aluResult = bus.alu_b;
            OP_BIC: aluResult = bus.alu_a & ~bus.alu_b;
            OP_MVN: aluResult = ~bus.alu_b;
`ifdef ALU_EXT_OPS_EN
            OP_INCA: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = WIDTH'(4);
            end
            OP_PASA: aluResult = bus.alu_a;
            OP_PASB: aluResult = bus.alu_b;
            OP_ADDA: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = bus.alu_b;
            end
            OP_SUBA: begin
                isArith = 1'b1;
                addX    = bus.alu_a;
                addY    = ~bus.alu_b;
                addCin  = 1'b1;
            end
            OP_INCB: begin
                isArith = 1'b1;
                addX    = bus.alu_b;
                addY    = WIDTH'(4);
            end
`endif
            default: aluResult = '0;
        endcase
        sum = {1'b0, addX} + {1'b0, addY} + (WIDTH + 1)'(addCin);
        if (isArith) begin
            aluResult = sum[WIDTH-1:0];
            flagC     = sum[WIDTH];
            flagV     = (addX[WIDTH-1] == addY[WIDTH-1]) && (sum[WIDTH-1] != addX[WIDTH-1]);
        end
    end

    assign bus.result = aluResult;
    assign bus.FlagZ  = (aluResult == '0);
    assign bus.FlagN  = aluResult[WIDTH-1];
    assign bus.FlagC  = flagC;
    assign bus.FlagV  = flagV;

    // Next-state for MAR and IR: load when enabled, otherwise hold
    always_comb begin
        marReg_d = bus.MARLd ? aluResult : marReg_q;
        irReg_d  = bus.IRLd ? bus.ir_d : irReg_q;
    end

    // MAR/IR registers; CLR wins over any coincident load
    always_ff @(posedge CLK) begin
        if (CLR) begin
            marReg_q <= '0;
            irReg_q  <= '0;
        end else begin
            marReg_q <= marReg_d;
            irReg_q  <= irReg_d;
        end
    end

    assign bus.mar_q = marReg_q;
    assign bus.ir_q  = irReg_q;

endmodule

// File: tb/tb_alu_ir_mar_datapath.sv
// tb_alu_ir_mar_datapath
// Randomized and directed stimulus for alu_ir_mar_datapath, checked against
// an arithmetic reference model. Honours ALU_EXT_OPS_EN like the design.
module tb_alu_ir_mar_datapath;

    logic clk;
    logic clr;
    int   checkCount;
    int   errorCount;

    logic [31:0] marModel;
    logic [31:0] irModel;

    alu_ir_mar_datapath_if #(.WIDTH(32)) bus ();

    alu_ir_mar_datapath #(.WIDTH(32)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // x + y + c evaluated as integers
    task automatic addModel(input logic [31:0] x, input logic [31:0] y, input logic c,
                            output logic [31:0] res, output logic co, output logic ov);
        longint u;
        longint s;
        u   = longint'(x) + longint'(y) + longint'(c);
        s   = longint'(int'(x)) + longint'(int'(y)) + longint'(c);
        res = u[31:0];
        co  = (u >= 64'h1_0000_0000);
        ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    // x - y - bw evaluated as integers; carry means no borrow
    task automatic subModel(input logic [31:0] x, input logic [31:0] y, input logic bw,
                            output logic [31:0] res, output logic co, output logic ov);
        longint u;
        longint s;
        u   = longint'(x) - longint'(y) - longint'(bw);
        s   = longint'(int'(x)) - longint'(int'(y)) - longint'(bw);
        res = u[31:0];
        co  = (longint'(x) >= longint'(y) + longint'(bw));
        ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    // Reference ALU; flags packed as {Z,N,C,V}
    task automatic refAlu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic cin, output logic [31:0] res, output logic [3:0] flags);
        logic co;
        logic ov;
        co = cin;
        ov = 1'b0;
        case (op)
            5'd0, 5'd8:   res = a & b;
            5'd1, 5'd9:   res = a ^ b;
            5'd2, 5'd10:  subModel(a, b, 1'b0, res, co, ov);
            5'd3:         subModel(b, a, 1'b0, res, co, ov);
            5'd4, 5'd11:  addModel(a, b, 1'b0, res, co, ov);
            5'd5:         addModel(a, b, cin, res, co, ov);
            5'd6:         subModel(a, b, !cin, res, co, ov);
            5'd7:         subModel(b, a, !cin, res, co, ov);
            5'd12:        res = a | b;
            5'd13:        res = b;
            5'd14:        res = a & ~b;
            5'd15:        res = ~b;
`ifdef ALU_EXT_OPS_EN
            5'd16:        addModel(a, 32'd4, 1'b0, res, co, ov);
            5'd17:        res = a;
            5'd18:        res = b;
            5'd19:        addModel(a, b, 1'b0, res, co, ov);
            5'd20:        subModel(a, b, 1'b0, res, co, ov);
            5'd21:        addModel(b, 32'd4, 1'b0, res, co, ov);
`endif
            default:      res = 32'd0;
        endcase
        flags = {(res == 32'd0), res[31], co, ov};
    endtask

    // Drive one cycle of inputs, check the ALU, clock it, check MAR/IR
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                 input logic cin, input logic marLd, input logic irLd,
                                 input logic [31:0] irD, input logic doClr);
        logic [31:0] expRes;
        logic [3:0]  expFlags;
        @(negedge clk);
        bus.alu_a    = a;
        bus.alu_b    = b;
        bus.alu_op   = op;
        bus.carry_in = cin;
        bus.MARLd    = marLd;
        bus.IRLd     = irLd;
        bus.ir_d     = irD;
        clr          = doClr;
        #1;
        refAlu(a, b, op, cin, expRes, expFlags);
        checkOutput($sformatf("result op%0d", op), bus.result, expRes);
        checkOutput($sformatf("flags op%0d", op),
                    {28'd0, bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV}, {28'd0, expFlags});
        @(posedge clk);
        if (doClr) begin
            marModel = 32'd0;
            irModel  = 32'd0;
        end else begin
            if (marLd) marModel = expRes;
            if (irLd)  irModel  = irD;
        end
        #1;
        checkOutput("mar_q", bus.mar_q, marModel);
        checkOutput("ir_q", bus.ir_q, irModel);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        marModel   = 32'd0;
        irModel    = 32'd0;
        clr        = 1'b1;
        bus.alu_a    = 32'd0;
        bus.alu_b    = 32'd0;
        bus.alu_op   = 5'd0;
        bus.carry_in = 1'b0;
        bus.MARLd    = 1'b0;
        bus.IRLd     = 1'b0;
        bus.ir_d     = 32'd0;

        // Reset state
        applyStimulus(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("reset mar", bus.mar_q, 32'd0);
        checkOutput("reset ir", bus.ir_q, 32'd0);

        // ADD overflow into sign bit
        applyStimulus(32'h7FFF_FFFF, 32'd1, 5'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("add result", bus.result, 32'h8000_0000);
        checkOutput("add flags", {28'd0, bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV}, 32'h5);

        // SUB equal operands, then borrow
        applyStimulus(32'd5, 32'd5, 5'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("sub zero flags", {28'd0, bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV}, 32'hA);
        applyStimulus(32'd0, 32'd1, 5'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("sub borrow result", bus.result, 32'hFFFF_FFFF);
        checkOutput("sub borrow flags", {28'd0, bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV}, 32'h4);

        // ADC wrap with carry in, MOV passes carry through
        applyStimulus(32'hFFFF_FFFF, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("adc flags", {28'd0, bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV}, 32'hA);
        applyStimulus(32'd0, 32'h12, 5'd13, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("mov result", bus.result, 32'h12);
        checkOutput("mov flags", {28'd0, bus.FlagZ, bus.FlagN, bus.FlagC, bus.FlagV}, 32'h2);

        // MAR load from op 16, then hold
        applyStimulus(32'h10, 32'd0, 5'd16, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
`ifdef ALU_EXT_OPS_EN
        checkOutput("mar a+4", bus.mar_q, 32'h14);
`else
        checkOutput("mar reserved", bus.mar_q, 32'h0);
`endif
        applyStimulus(32'h99, 32'h5, 5'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
`ifdef ALU_EXT_OPS_EN
        checkOutput("mar hold", bus.mar_q, 32'h14);
`else
        checkOutput("mar hold", bus.mar_q, 32'h0);
`endif

        // IR load, then hold while ir_d changes
        applyStimulus(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hE281_1005, 1'b0);
        checkOutput("ir load", bus.ir_q, 32'hE281_1005);
        applyStimulus(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
        checkOutput("ir hold", bus.ir_q, 32'hE281_1005);

        // Reset beats coincident loads; ALU still live
        applyStimulus(32'h3, 32'h4, 5'd4, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        checkOutput("clr mar", bus.mar_q, 32'd0);
        checkOutput("clr ir", bus.ir_q, 32'd0);
        checkOutput("clr alu", bus.result, 32'h7);

        // Randomized traffic over all ops, including operand corner values
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h7FFF_FFFF;
                1: b = 32'h8000_0000;
                2: b = a;
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            applyStimulus(a, b, 5'($urandom_range(0, 31)), 1'($urandom),
                          1'($urandom), 1'($urandom), $urandom,
                          ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu_ir_mar_datapath.md
# alu_ir_mar_datapath

Combinational 32-bit ALU with its two directly fed datapath registers: the Memory Address Register (MAR), which captures the ALU result, and the Instruction Register (IR), which captures the memory data-out bus. It sits between the register file/shifter operand muxes and the RAM/control unit of the multicycle CPU. The ALU result and flags drive the result bus, the MDR input mux and the flag register. MAR drives the RAM address and IR drives the control unit and operand-select muxes.

## Interface
Parameters:
- WIDTH, 32, datapath width (only 32 required/verified)

Ports:
- CLK  in  1  system clock, rising-edge active
- CLR  in  1  synchronous active-high reset
- alu_a  in  32  operand A (register file port A)
- alu_b  in  32  operand B (shifter/MDR mux output)
- alu_op  in  5  operation select
- carry_in  in  1  carry input (flag-register C)
- result  out  32  ALU result, combinational
- FlagZ, FlagN, FlagC, FlagV  out  1 each  combinational flags
- MARLd  in  1  MAR load enable
- mar_q  out  32  MAR contents
- IRLd  in  1  IR load enable
- ir_d  in  32  IR data input (RAM data-out)
- ir_q  out  32  IR contents

## Operation
ALU ops 0–15 use the ARM data-processing encoding:
- 0 AND, 1 EOR, 2 SUB A−B, 3 RSB B−A, 4 ADD, 5 ADC A+B+cin, 6 SBC A−B−!cin, 7 RSC B−A−!cin.
- 8 TST (A&B), 9 TEQ (A^B), 10 CMP (A−B), 11 CMN (A+B): result bus still carries the computed value; suppressing writeback is the control unit's job.
- 12 ORR, 13 MOV (B), 14 BIC (A&~B), 15 MVN (~B).

Extended ops (`ALU_EXT_OPS_EN`):
- 16 A+4, 17 pass A, 18 pass B, 19 A+B (address add, flags as ADD), 20 A−B (as SUB), 21 B+4.
- 22–31 reserved: result 0.

Flags:
- Z = (result == 0); N = result[31].
- Arithmetic ops: C = carry out of the 33-bit add. Subtraction is computed as X + ~Y + 1 (or + cin for SBC/RSC), so C = 1 means no borrow.
- V = signed overflow: operands of equal sign as effectively added, result sign differs.
- Logical/move/pass ops: C = carry_in, V = 0.
- Reserved ops: result 0, Z=1, N=0, C=carry_in, V=0.

Registers:
- MAR: on rising CLK, if CLR then 0, else if MARLd then mar_q <= result; otherwise hold.
- IR: on rising CLK, if CLR then 0, else if IRLd then ir_q <= ir_d; otherwise hold.
- CLR has priority over both load enables.
- MARLd and IRLd are independent; both may be asserted in the same cycle.

## Timing
- ALU is purely combinational: result and flags settle within the same cycle as their inputs. No latency, no internal state.
- MAR/IR: one-cycle latency. Value present before the rising edge with Ld=1 appears on the output immediately after that edge.
- Reset: mar_q = 0 and ir_q = 0 after the first rising edge with CLR=1. ALU outputs are unaffected by CLR.
- CLR asserted mid-operation, including coincident with a load, clears the register on that edge and the load is discarded.
- MAR captures the ALU result of the same cycle, so the ALU inputs must be stable before the loading edge.
- No handshakes; the Ld signals are level enables sampled at the edge.

## Configuration
- `ALU_EXT_OPS_EN` defined: ops 16–21 implemented as listed.
- `ALU_EXT_OPS_EN` undefined: ops 16–31 all behave as reserved (result 0, Z=1, N=0, C=carry_in, V=0). Ops 0–15 and the registers are unchanged.

## Test plan
- ADD, op 4: A=0x7FFFFFFF, B=1 → result 0x80000000, N=1, Z=0, C=0, V=1.
- SUB, op 2: A=5, B=5 → result 0, Z=1, C=1, V=0; A=0, B=1 → 0xFFFFFFFF, N=1, C=0.
- ADC with cin=1, op 5: A=0xFFFFFFFF, B=0 → result 0, Z=1, C=1. MOV, op 13, with cin=1 and B=0x12 → result 0x12, C=1, V=0.
- MAR: A=0x10, op 16 (ext on), MARLd=1 for one edge → mar_q=0x14. Next edge with MARLd=0 → holds 0x14. With macro off, same stimulus → mar_q=0.
- IR: ir_d=0xE2811005, IRLd=1 → ir_q=0xE2811005 after the edge. Change ir_d with IRLd=0 → ir_q unchanged.
- Reset priority: CLR=1 with MARLd=IRLd=1 and nonzero inputs → mar_q=0, ir_q=0. ALU result still valid in the same cycle.
